alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, parametrised successor of the core ALU. Takes one operation per valid/ready
//  handshake and returns the result plus flags (Z,N,C,V) and status on a valid/ready output.
//  Single-cycle ops (CMP/ADD/SUB/OR/XOR/AND/MOVE) complete in 1 cycle.
//  MUL/DIV/REM use an iterative shift-add/shift-subtract engine taking OPTION_REG_WIDTH cycles.
//  Sits between the register-file read stage and writeback.
// PARAMETERS
//  OPTION_REG_WIDTH  64         operand/result width; legal values 8..64, must be even
//  FEATURE_MUL       "ENABLED"  "ENABLED"/"NONE": MULS, MULU
//  FEATURE_DIV       "ENABLED"  "ENABLED"/"NONE": DIVS, DIVU
//  FEATURE_REM       "ENABLED"  "ENABLED"/"NONE": REMS, REMU
//  FEATURE_MOVE      "ENABLED"  "ENABLED"/"NONE": MOVE
// PORTS
//  clk        in   1   clock; all state changes on rising edge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   operation presented
//  in_ready   out  1   block can accept an operation this cycle
//  opcode     in   4   operation, encoding in alu_pkg
//  rega       in   W   operand A (W = OPTION_REG_WIDTH)
//  regb       in   W   operand B
//  out_valid  out  1   result/flags valid; held until out_ready
//  out_ready  in   1   consumer accepts result
//  result     out  W   result value
//  out_wb     out  1   1 = result must be written back (0 for CMP and illegal ops)
//  flags      out  4   {Z,N,C,V} for this result
//  illegal    out  1   opcode undefined or its feature is disabled
//  div_zero   out  1   DIV/REM with regb == 0
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; result, flags, out_wb, illegal, div_zero = 0.
//    Reset mid-operation aborts the operation; no output is produced.
//  - FSM states:
//    - IDLE: accept when in_valid & in_ready.
//      Single-cycle or illegal ops go to DONE; MUL* goes to MUL; DIV*/REM* goes to DIV.
//    - MUL, DIV: exactly W iterations, then DONE.
//    - DONE: out_valid=1, outputs stable until out_ready.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready).
//    Accepting in DONE gives back-to-back throughput of 1 op/cycle for single-cycle ops.
//  - Latency, accept to out_valid: 1 cycle for single-cycle ops; W+1 cycles for MUL/DIV/REM.
//  - Operands and opcode are captured at accept; input changes afterwards are ignored.
//  - ADD: result = A+B; C = carry-out; V = (A[W-1]==B[W-1]) & (A[W-1]^result[W-1]).
//  - SUB and CMP: A + ~B + 1; C = no-borrow (carry-out); V is signed overflow of the subtraction.
//    CMP sets out_wb=0.
//  - OR/XOR/AND/MOVE(result=A): C=0, V=0.
//  - Z = (result==0) and N = result[W-1] for every legal op.
//  - MULS/MULU: result = low W bits of the product.
//    V=1 if the full 2W product does not fit (unsigned: high half !=0; signed: high half
//    is not the sign-extension of result). C=0.
//  - DIVU/REMU: quotient/remainder, restoring division.
//  - DIVS/REMS: magnitudes are divided; quotient sign = A^B; remainder takes the sign of A.
//  - Divide by zero: quotient = all-ones, remainder = A; div_zero=1; still W+1 cycles latency.
//  - DIVS with A=MIN, B=-1: quotient = MIN, remainder = 0, V=1.
//  - Illegal opcode: result=0, flags=0, out_wb=0, illegal=1, latency 1.
//  - A disabled feature's opcodes behave as illegal; its engine logic is not generated.
// STRUCTURE
//  - alu_pkg: opcode localparams CMP=0 ADD=1 SUB=2 OR=3 XOR=4 AND=5 MULS=6 MULU=7 MOVE=8
//    DIVS=9 DIVU=A REMS=B REMU=C (D-F illegal); FSM state encodings; flag bit indices.
//  - Sub-module alu_iter_engine: shared W-cycle shift-add/shift-subtract datapath.
//    Inputs: start, mode (mul/div), |A|, |B|. Outputs: done, hi/lo.
//    Generated only if any of FEATURE_MUL/FEATURE_DIV/FEATURE_REM is enabled.
// TESTING (W=64 unless noted)
//  - ADD 0x7FFF..F + 1 -> result 0x8000..0, V=1, N=1, C=0, latency 1, out_wb=1.
//  - CMP 5,5 then SUB 3,5 back-to-back with out_ready=1
//    -> both accepted on consecutive cycles; CMP Z=1 C=1 out_wb=0; SUB result=-2 N=1 C=0.
//  - MULS -3*7 -> result=-21, V=0, out_valid exactly 65 cycles after accept.
//    MULU 2^63*2 -> result 0, V=1.
//  - DIVS -7/2 -> result -3; REMS -7/2 -> result -1; DIVU 10/0 -> result all-ones, div_zero=1.
//    REMU 10/0 -> result 10.
//  - Assert rst at iteration 30 of DIVU -> next cycle in_ready=1, out_valid=0;
//    new ADD 1+1 returns 2.
//  - W=32, FEATURE_DIV="NONE": DIVU -> illegal=1, latency 1.
//    Opcode 0xF -> illegal=1; out_valid held while out_ready=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states and flag bit positions.
// Imported by alu_mc and alu_iter_engine.
package alu_pkg;

    localparam logic [3:0] OP_CMP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_MULS = 4'h6;
    localparam logic [3:0] OP_MULU = 4'h7;
    localparam logic [3:0] OP_MOVE = 4'h8;
    localparam logic [3:0] OP_DIVS = 4'h9;
    localparam logic [3:0] OP_DIVU = 4'hA;
    localparam logic [3:0] OP_REMS = 4'hB;
    localparam logic [3:0] OP_REMU = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULS) || (op == OP_DIVS) || (op == OP_REMS);
    endfunction

endpackage

// File: rtl/alu_iter_engine.sv
// Iterative W-cycle engine: shift-add multiply (mode_div=0) or restoring divide (mode_div=1)
// on unsigned magnitudes. Multiply leaves the product in {hi,lo}; divide leaves rem in hi, quotient in lo.
module alu_iter_engine #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CW = $clog2(W);

    logic          busy_reg;
    logic          mode_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  hi_reg, lo_reg, b_reg;
    logic [W-1:0]  hi_next, lo_next;
    logic [W:0]    mul_sum, shifted;
    logic [W-1:0]  diff;

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        shifted = {hi_reg, lo_reg[W-1]};
        // When shifted >= b the true difference is below b, so W bits hold it exactly.
        diff    = shifted[W-1:0] - b_reg;
        if (mode_reg) begin
            if (shifted >= {1'b0, b_reg}) begin
                hi_next = diff;
                lo_next = {lo_reg[W-2:0], 1'b1};
            end else begin
                hi_next = shifted[W-1:0];
                lo_next = {lo_reg[W-2:0], 1'b0};
            end
        end else begin
            hi_next = mul_sum[W:1];
            lo_next = {mul_sum[0], lo_reg[W-1:1]};
        end
    end

    assign done = busy_reg && (cnt_reg == CW'(W - 1));
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            mode_reg <= 1'b0;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            b_reg    <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            mode_reg <= mode_div;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= a;
            b_reg    <= b;
        end else if (busy_reg) begin
            hi_reg   <= hi_next;
            lo_reg   <= lo_next;
            cnt_reg  <= cnt_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready in and out. Single-cycle ops finish in one cycle;
// MUL/DIV/REM run on a shared iterative engine for W cycles. Outputs are zero unless in DONE.
module alu_mc
    import alu_pkg::*;
#(
    parameter int    OPTION_REG_WIDTH = 64,
    parameter string FEATURE_MUL      = "ENABLED",
    parameter string FEATURE_DIV      = "ENABLED",
    parameter string FEATURE_REM      = "ENABLED",
    parameter string FEATURE_MOVE     = "ENABLED"
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  opcode,
    input  logic [OPTION_REG_WIDTH-1:0] rega,
    input  logic [OPTION_REG_WIDTH-1:0] regb,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPTION_REG_WIDTH-1:0] result,
    output logic                        out_wb,
    output logic [3:0]                  flags,
    output logic                        illegal,
    output logic                        div_zero
);

    localparam int W = OPTION_REG_WIDTH;
    localparam bit HAS_MUL    = (FEATURE_MUL == "ENABLED");
    localparam bit HAS_DIV    = (FEATURE_DIV == "ENABLED");
    localparam bit HAS_REM    = (FEATURE_REM == "ENABLED");
    localparam bit HAS_MOVE   = (FEATURE_MOVE == "ENABLED");
    localparam bit HAS_ENGINE = HAS_MUL || HAS_DIV || HAS_REM;
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_CMP, OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND: return 1'b1;
            OP_MULS, OP_MULU: return HAS_MUL;
            OP_MOVE:          return HAS_MOVE;
            OP_DIVS, OP_DIVU: return HAS_DIV;
            OP_REMS, OP_REMU: return HAS_REM;
            default:          return 1'b0;
        endcase
    endfunction

    state_t        state_reg, state_next;
    logic [3:0]    op_reg;
    logic [W-1:0]  a_reg, b_reg;
    logic          accept, in_legal, in_mul, in_div;
    logic          eng_start, eng_done;
    logic [W-1:0]  eng_a, eng_b, eng_hi, eng_lo;

    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign in_legal  = op_legal(opcode);
    assign in_mul    = in_legal && ((opcode == OP_MULS) || (opcode == OP_MULU));
    assign in_div    = in_legal && (opcode >= OP_DIVS) && (opcode <= OP_REMU);
    assign eng_start = accept && (in_mul || in_div);
    assign eng_a     = (is_signed_op(opcode) && rega[W-1]) ? -rega : rega;
    assign eng_b     = (is_signed_op(opcode) && regb[W-1]) ? -regb : regb;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_next = in_mul ? ST_MUL : (in_div ? ST_DIV : ST_DONE);
                end else if ((state_reg == ST_DONE) && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (eng_done) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg <= opcode;
                a_reg  <= rega;
                b_reg  <= regb;
            end
        end
    end

    generate
        if (HAS_ENGINE) begin : g_engine
            alu_iter_engine #(.W(W)) u_engine (
                .clk      (clk),
                .rst      (rst),
                .start    (eng_start),
                .mode_div (in_div),
                .a        (eng_a),
                .b        (eng_b),
                .done     (eng_done),
                .hi       (eng_hi),
                .lo       (eng_lo)
            );
        end else begin : g_no_engine
            assign eng_done = 1'b0;
            assign eng_hi   = '0;
            assign eng_lo   = '0;
        end
    endgenerate

    logic [W:0]     add_sum, sub_sum;
    logic [2*W-1:0] prod_mag, prod;
    logic [W-1:0]   quo, rem, res;
    logic           a_neg, b_neg, c_flag, v_flag, wb, dz, legal_reg, done_st;

    always_comb begin
        a_neg    = a_reg[W-1];
        b_neg    = b_reg[W-1];
        add_sum  = {1'b0, a_reg} + {1'b0, b_reg};
        sub_sum  = {1'b0, a_reg} + {1'b0, ~b_reg} + (W+1)'(1);
        prod_mag = {eng_hi, eng_lo};
        prod     = ((op_reg == OP_MULS) && (a_neg ^ b_neg)) ? -prod_mag : prod_mag;
        quo      = ((op_reg == OP_DIVS) && (a_neg ^ b_neg)) ? -eng_lo : eng_lo;
        rem      = ((op_reg == OP_REMS) && a_neg) ? -eng_hi : eng_hi;
        dz       = (op_reg >= OP_DIVS) && (op_reg <= OP_REMU) && (b_reg == '0);
        res      = '0;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        wb       = 1'b1;
        case (op_reg)
            OP_CMP, OP_SUB: begin
                res    = sub_sum[W-1:0];
                c_flag = sub_sum[W];
                v_flag = (a_neg != b_neg) && (a_neg != res[W-1]);
                wb     = (op_reg != OP_CMP);
            end
            OP_ADD: begin
                res    = add_sum[W-1:0];
                c_flag = add_sum[W];
                v_flag = (a_neg == b_neg) && (a_neg != res[W-1]);
            end
            OP_OR:   res = a_reg | b_reg;
            OP_XOR:  res = a_reg ^ b_reg;
            OP_AND:  res = a_reg & b_reg;
            OP_MOVE: res = a_reg;
            OP_MULS: begin
                res    = prod[W-1:0];
                v_flag = prod[2*W-1:W] != {W{res[W-1]}};
            end
            OP_MULU: begin
                res    = prod[W-1:0];
                v_flag = |prod[2*W-1:W];
            end
            OP_DIVS, OP_DIVU: begin
                res    = dz ? '1 : quo;
                v_flag = (op_reg == OP_DIVS) && (a_reg == MIN_VAL) && (b_reg == '1);
            end
            OP_REMS, OP_REMU: res = dz ? a_reg : rem;
            default: wb = 1'b0;
        endcase
    end

    assign done_st   = (state_reg == ST_DONE);
    assign legal_reg = op_legal(op_reg);
    assign out_valid = done_st;
    assign result    = (done_st && legal_reg) ? res : '0;
    assign out_wb    = done_st && legal_reg && wb;
    assign illegal   = done_st && !legal_reg;
    assign div_zero  = done_st && legal_reg && dz;

    always_comb begin
        flags = '0;
        if (done_st && legal_reg) begin
            flags[FLAG_Z] = (res == '0);
            flags[FLAG_N] = res[W-1];
            flags[FLAG_C] = c_flag;
            flags[FLAG_V] = v_flag;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: scoreboard-checked 64-bit instance plus a 32-bit instance
// with division disabled; scenario tasks run in sequence from one initial block.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready;
    logic [3:0]   opcode;
    logic [W-1:0] rega, regb;
    logic         in_ready, out_valid, out_wb, illegal, div_zero;
    logic [W-1:0] result;
    logic [3:0]   flags;

    logic         s_in_valid, s_out_ready;
    logic [3:0]   s_opcode;
    logic [31:0]  s_rega, s_regb;
    logic         s_in_ready, s_out_valid, s_out_wb, s_illegal, s_div_zero;
    logic [31:0]  s_result;
    logic [3:0]   s_flags;

    alu_mc #(.OPTION_REG_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .rega(rega), .regb(regb), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_wb(out_wb), .flags(flags), .illegal(illegal), .div_zero(div_zero)
    );

    alu_mc #(.OPTION_REG_WIDTH(32), .FEATURE_DIV("NONE")) dut32 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .opcode(s_opcode),
        .rega(s_rega), .regb(s_regb), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .out_wb(s_out_wb), .flags(s_flags), .illegal(s_illegal),
        .div_zero(s_div_zero)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;   // {Z,N,C,V}
        logic         wb;
        logic         ill;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t ex(input logic [W-1:0] r, input logic [3:0] f,
                                input logic w, input logic i, input logic d);
        exp_t e;
        e.res = r; e.fl = f; e.wb = w; e.ill = i; e.dz = d;
        return e;
    endfunction

    // Independent reference for the random section (unsigned ops and logic ops).
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]     s;
        logic [2*W-1:0] p;
        logic [W-1:0]   r;
        logic           c, v, dz;
        c = 1'b0; v = 1'b0; dz = 1'b0; r = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                v = (a[W-1] == b[W-1]) && (a[W-1] != r[W-1]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = (a >= b);
                v = (a[W-1] != b[W-1]) && (a[W-1] != r[W-1]);
            end
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_MOVE: r = a;
            OP_MULU: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; v = (p[2*W-1:W] != 0);
            end
            OP_DIVU: begin dz = (b == 0); r = dz ? '1 : a / b; end
            default: begin dz = (b == 0); r = dz ? a : a % b; end
        endcase
        return ex(r, {r == 0, r[W-1], c, v}, 1'b1, 1'b0, dz);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (!rst && out_valid && out_ready) begin
            got = ex(result, flags, out_wb, illegal, div_zero);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got res=%h fl=%b, required no output", result, flags);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard: got res=%h fl=%b wb=%b ill=%b dz=%b, required res=%h fl=%b wb=%b ill=%b dz=%b",
                             got.res, got.fl, got.wb, got.ill, got.dz, e.res, e.fl, e.wb, e.ill, e.dz);
                end else begin
                    $display("txn ok res=%h fl=%b wb=%b ill=%b dz=%b", got.res, got.fl, got.wb, got.ill, got.dz);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input exp_t e, output int acc_cyc);
        int guard;
        guard = 0;
        opcode = op; rega = a; regb = b; in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 300) begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 300 cycles", in_ready);
            void'(sb.pop_back());
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        opcode = 4'($urandom_range(0, 15));
        rega = {$urandom, $urandom};
        regb = {$urandom, $urandom};
    endtask

    task automatic drain;
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || flags !== 4'b0 ||
            out_wb !== 1'b0 || illegal !== 1'b0 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: rdy=%b ov=%b res=%h fl=%b wb=%b ill=%b dz=%b, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, result, flags, out_wb, illegal, div_zero);
        end
        vectors++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_result !== '0) begin
            miscompares++;
            $display("FAIL reset_state32: rdy=%b ov=%b res=%h, required 1 0 0", s_in_ready, s_out_valid, s_result);
        end
    endtask

    task automatic test_add;
        int acc;
        logic [W-1:0] maxpos;
        maxpos = {1'b0, {(W-1){1'b1}}};
        send(OP_ADD, maxpos, 64'd1, ex({1'b1, {(W-1){1'b0}}}, 4'b0101, 1'b1, 1'b0, 1'b0), acc);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL add_latency: out_valid=%b one cycle after accept, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_back_to_back;
        int acc1, acc2;
        send(OP_CMP, 64'd5, 64'd5, ex('0, 4'b1010, 1'b0, 1'b0, 1'b0), acc1);
        send(OP_SUB, 64'd3, 64'd5, ex(-64'sd2, 4'b0100, 1'b1, 1'b0, 1'b0), acc2);
        vectors++;
        if (acc2 - acc1 !== 1) begin
            miscompares++;
            $display("FAIL back_to_back: accept gap=%0d cycles, required 1", acc2 - acc1);
        end
        drain();
    endtask

    task automatic test_mul;
        int acc, lat;
        send(OP_MULS, -64'sd3, 64'd7, ex(-64'sd21, 4'b0100, 1'b1, 1'b0, 1'b0), acc);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== W + 1) begin
            miscompares++;
            $display("FAIL mul_latency: latency=%0d, required %0d", lat, W + 1);
        end
        drain();
        send(OP_MULU, {1'b1, {(W-1){1'b0}}}, 64'd2, ex('0, 4'b1001, 1'b1, 1'b0, 1'b0), acc);
        send(OP_MULS, {1'b1, {(W-1){1'b0}}}, 64'd1, ex({1'b1, {(W-1){1'b0}}}, 4'b0100, 1'b1, 1'b0, 1'b0), acc);
        drain();
    endtask

    task automatic test_div;
        int acc;
        send(OP_DIVS, -64'sd7, 64'd2, ex(-64'sd3, 4'b0100, 1'b1, 1'b0, 1'b0), acc);
        send(OP_REMS, -64'sd7, 64'd2, ex(-64'sd1, 4'b0100, 1'b1, 1'b0, 1'b0), acc);
        send(OP_DIVU, 64'd10, 64'd0, ex('1, 4'b0100, 1'b1, 1'b0, 1'b1), acc);
        send(OP_REMU, 64'd10, 64'd0, ex(64'd10, 4'b0000, 1'b1, 1'b0, 1'b1), acc);
        send(OP_DIVS, {1'b1, {(W-1){1'b0}}}, '1, ex({1'b1, {(W-1){1'b0}}}, 4'b0101, 1'b1, 1'b0, 1'b0), acc);
        send(OP_REMS, {1'b1, {(W-1){1'b0}}}, '1, ex('0, 4'b1000, 1'b1, 1'b0, 1'b0), acc);
        drain();
    endtask

    task automatic test_illegal_hold;
        int acc;
        logic [W-1:0] held;
        send(4'hF, 64'd9, 64'd9, ex('0, 4'b0000, 1'b0, 1'b1, 1'b0), acc);
        drain();
        out_ready = 1'b0;
        send(OP_XOR, 64'hF0F0, 64'h0FF0, ex(64'hFF00, 4'b0000, 1'b1, 1'b0, 1'b0), acc);
        held = result;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: ov=%b res=%h rdy=%b, required 1 %h 0", out_valid, result, in_ready, held);
        end
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_abort;
        int acc;
        send(OP_DIVU, 64'd100, 64'd7, ex(64'd14, 4'b0000, 1'b1, 1'b0, 1'b0), acc);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
        end
        send(OP_ADD, 64'd1, 64'd1, ex(64'd2, 4'b0000, 1'b1, 1'b0, 1'b0), acc);
        drain();
    endtask

    task automatic test_random;
        logic [3:0] ops [9];
        logic [3:0] op;
        logic [W-1:0] a, b;
        int acc;
        ops = '{OP_ADD, OP_SUB, OP_OR, OP_XOR, OP_AND, OP_MOVE, OP_MULU, OP_DIVU, OP_REMU};
        for (int i = 0; i < 18; i++) begin
            op = ops[$urandom_range(0, 8)];
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
            if ($urandom_range(0, 7) == 0) b = '0;
            send(op, a, b, model(op, a, b), acc);
        end
        drain();
    endtask

    task automatic test_feature_off;
        int lat;
        s_out_ready = 1'b1;
        s_opcode = OP_DIVU; s_rega = 32'd10; s_regb = 32'd2; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        vectors++;
        if (s_out_valid !== 1'b1 || s_illegal !== 1'b1 || s_result !== '0 || s_out_wb !== 1'b0 || s_flags !== 4'b0) begin
            miscompares++;
            $display("FAIL divu_disabled: ov=%b ill=%b res=%h wb=%b fl=%b, required 1 1 0 0 0",
                     s_out_valid, s_illegal, s_result, s_out_wb, s_flags);
        end
        @(posedge clk);
        #1;
        s_opcode = OP_REMU; s_rega = 32'd10; s_regb = 32'd3; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (lat !== 33 || s_result !== 32'd1 || s_illegal !== 1'b0 || s_out_wb !== 1'b1 || s_flags !== 4'b0) begin
            miscompares++;
            $display("FAIL remu32: lat=%0d res=%h ill=%b wb=%b fl=%b, required 33 1 0 1 0",
                     lat, s_result, s_illegal, s_out_wb, s_flags);
        end
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        s_opcode = 4'hF; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (s_out_valid !== 1'b1 || s_illegal !== 1'b1 || s_in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_hold32: ov=%b ill=%b rdy=%b, required 1 1 0", s_out_valid, s_illegal, s_in_ready);
        end
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (s_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL release32: ov=%b, required 0", s_out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; rega = '0; regb = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_opcode = '0; s_rega = '0; s_regb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_div();
        test_illegal_hold();
        test_reset_abort();
        test_random();
        test_feature_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
